// File: rtl/seg7_pkg.sv
// Glyph table and ASCII codes shared by the 7-segment scan driver and its decoder.
// Segment vectors are {g,f,e,d,c,b,a}, active-high; polarity is applied only at the output flops.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_BLANK = 8'h20;

  localparam int unsigned NUM_DIGITS = 4;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    g = SEG_BLANK;
    case (d)
      4'd0: g = SEG_0;
      4'd1: g = SEG_1;
      4'd2: g = SEG_2;
      4'd3: g = SEG_3;
      4'd4: g = SEG_4;
      4'd5: g = SEG_5;
      4'd6: g = SEG_6;
      4'd7: g = SEG_7;
      4'd8: g = SEG_8;
      4'd9: g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Anode bit 3 is the leftmost digit (hour tens), bit 0 the rightmost.
  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/ascii_to_seg7.sv
// Purely combinational ASCII-to-glyph decode: '0'..'9' and '-' map to glyphs, anything else is blank.
// Zero latency; no flow control.
module ascii_to_seg7
  import seg7_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (ascii >= ASCII_ZERO && ascii <= ASCII_NINE) begin
      seg = digit_glyph(ascii[3:0]);
    end else if (ascii == ASCII_DASH) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment driver with frame-latched digits, blinking colon and alarm flash.
// seg/digit_an/colon are registered one cycle after digit_idx; no backpressure, inputs sampled once per frame.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 64,
  parameter int unsigned BLINK_DIV    = 256,
  parameter bit          COMMON_ANODE = 1'b0,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ms_hour,
  input  logic [7:0] ls_hour,
  input  logic [7:0] ms_minute,
  input  logic [7:0] ls_minute,
  input  logic       alarm_sound,
  input  logic       display_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic       colon,
  output logic [3:0] digit_an
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  // Polarity masks folded into the output flops so pins come straight from registers.
  localparam logic [6:0] SEG_INV = {7{COMMON_ANODE}};
  localparam logic [3:0] AN_INV  = {4{COMMON_ANODE}};

  logic [RW-1:0]     refresh_cnt;
  logic [BW-1:0]     blink_cnt;
  logic [1:0]        digit_idx;
  logic              blink_phase;
  logic [3:0][7:0]   shadow;

  logic [6:0]        seg_q;
  logic [3:0]        an_q;
  logic              colon_q;

  logic              refresh_tc;
  logic              blink_tc;
  logic              frame_wrap;
  logic [7:0]        cur_byte;
  logic [6:0]        glyph;
  logic              lz_hide;
  logic              flash_dark;
  logic [6:0]        seg_log;
  logic [3:0]        an_log;
  logic              colon_log;

  assign refresh_tc = (refresh_cnt == REFRESH_LAST);
  assign blink_tc   = (blink_cnt == BLINK_LAST);
  // Shadows reload only as the scan returns to the leftmost digit, so a frame never tears.
  assign frame_wrap = refresh_tc && (digit_idx == 2'd0);
  assign cur_byte   = shadow[digit_idx];

  ascii_to_seg7 u_decode (
    .ascii (cur_byte),
    .seg   (glyph)
  );

  assign lz_hide    = LZ_BLANK && (digit_idx == 2'd3) && (cur_byte == ASCII_ZERO);
  assign flash_dark = alarm_sound && !blink_phase;

  always_comb begin
    seg_log   = SEG_BLANK;
    an_log    = 4'b0000;
    colon_log = 1'b0;
    if (display_en) begin
      seg_log   = lz_hide ? SEG_BLANK : glyph;
      an_log    = flash_dark ? 4'b0000 : digit_onehot(digit_idx);
      colon_log = blink_phase;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      digit_idx   <= 2'd0;
      blink_phase <= 1'b0;
      shadow      <= {NUM_DIGITS{ASCII_BLANK}};
      seg_q       <= SEG_BLANK ^ SEG_INV;
      an_q        <= 4'b0000 ^ AN_INV;
      colon_q     <= COMMON_ANODE;
    end else begin
      refresh_cnt <= refresh_tc ? '0 : refresh_cnt + RW'(1);
      blink_cnt   <= blink_tc ? '0 : blink_cnt + BW'(1);
      if (blink_tc) begin
        blink_phase <= ~blink_phase;
      end
      if (refresh_tc) begin
        digit_idx <= digit_idx - 2'd1;
      end
      if (frame_wrap) begin
        shadow <= {ms_hour, ls_hour, ms_minute, ls_minute};
      end
      seg_q   <= seg_log ^ SEG_INV;
      an_q    <= an_log ^ AN_INV;
      colon_q <= colon_log ^ COMMON_ANODE;
    end
  end

  assign seg      = seg_q;
  assign digit_an = an_q;
  assign colon    = colon_q;
  assign dp       = COMMON_ANODE;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one common-cathode and one common-anode instance share stimulus.
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
  localparam logic [6:0] GDASH = 7'h40, GBLANK = 7'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ms_hour = 8'h20, ls_hour = 8'h20, ms_minute = 8'h20, ls_minute = 8'h20;
  logic       alarm_sound = 1'b0;
  logic       display_en = 1'b1;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1, colon0, colon1;
  logic [3:0] an0, an1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  seg7_scan_driver #(.REFRESH_DIV(64), .BLINK_DIV(256), .COMMON_ANODE(1'b0), .LZ_BLANK(1'b1)) dut_cc (
    .clock(clk), .reset(reset), .ms_hour(ms_hour), .ls_hour(ls_hour), .ms_minute(ms_minute),
    .ls_minute(ls_minute), .alarm_sound(alarm_sound), .display_en(display_en),
    .seg(seg0), .dp(dp0), .colon(colon0), .digit_an(an0)
  );

  seg7_scan_driver #(.REFRESH_DIV(64), .BLINK_DIV(256), .COMMON_ANODE(1'b1), .LZ_BLANK(1'b1)) dut_ca (
    .clock(clk), .reset(reset), .ms_hour(ms_hour), .ls_hour(ls_hour), .ms_minute(ms_minute),
    .ls_minute(ls_minute), .alarm_sound(alarm_sound), .display_en(display_en),
    .seg(seg1), .dp(dp1), .colon(colon1), .digit_an(an1)
  );

  // Leaves the bench at the falling edge following rising edge k after reset release.
  task automatic wait_cycle(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != k) begin
      errors++;
      $display("FAIL wait_cycle reached=%0d want=%0d", cyc, k);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b0;
    ms_hour = 8'h31; ls_hour = 8'h31; ms_minute = 8'h32; ls_minute = 8'h33;
    display_en = 1'b1; alarm_sound = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (seg0 !== GBLANK) begin errors++; $display("FAIL reset_seg got=%h want=%h", seg0, GBLANK); end
    checks++; if (an0 !== 4'b0000) begin errors++; $display("FAIL reset_an got=%b want=0000", an0); end
    checks++; if (colon0 !== 1'b0 || dp0 !== 1'b0) begin errors++; $display("FAIL reset_colon_dp got=%b%b want=00", colon0, dp0); end
    checks++; if ({seg1, an1, colon1, dp1} !== 13'h1FFF) begin errors++; $display("FAIL reset_ca got=%h want=1fff", {seg1, an1, colon1, dp1}); end
    reset = 1'b1;
    n = 0;
    while (an0 !== 4'b1000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 65) begin errors++; $display("FAIL first_digit_latency got=%0d want=65", n); end
  endtask

  task automatic test_scan;
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_col [4];
    exp_an  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    exp_seg = '{G1, G1, G2, G3};
    exp_col = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      wait_cycle(65 + 64 * i);
      checks++; if (an0 !== exp_an[i]) begin errors++; $display("FAIL scan_an[%0d] got=%b want=%b", i, an0, exp_an[i]); end
      checks++; if (seg0 !== exp_seg[i]) begin errors++; $display("FAIL scan_seg[%0d] got=%h want=%h", i, seg0, exp_seg[i]); end
      checks++; if (colon0 !== exp_col[i]) begin errors++; $display("FAIL scan_colon[%0d] got=%b want=%b", i, colon0, exp_col[i]); end
      checks++; if (an1 !== ~exp_an[i] || seg1 !== ~exp_seg[i] || colon1 !== ~exp_col[i] || dp1 !== 1'b1)
        begin errors++; $display("FAIL scan_ca[%0d] got=%b/%h/%b/%b want inverse of %b/%h/%b/0", i, an1, seg1, colon1, dp1, exp_an[i], exp_seg[i], exp_col[i]); end
    end
  endtask

  task automatic test_frame_latch;
    wait_cycle(270);
    ls_minute = 8'h34;
    wait_cycle(300);
    checks++; if (an0 !== 4'b0001 || seg0 !== G3) begin errors++; $display("FAIL latch_old got=%b/%h want=0001/%h", an0, seg0, G3); end
    wait_cycle(449);
    checks++; if (an0 !== 4'b0010 || seg0 !== G2) begin errors++; $display("FAIL latch_mid got=%b/%h want=0010/%h", an0, seg0, G2); end
    wait_cycle(513);
    checks++; if (an0 !== 4'b0001 || seg0 !== G4) begin errors++; $display("FAIL latch_new got=%b/%h want=0001/%h", an0, seg0, G4); end
  endtask

  task automatic test_blanking;
    wait_cycle(520);
    ms_hour = 8'h30; ls_minute = 8'h30;
    wait_cycle(600);
    checks++; if (an0 !== 4'b1000 || seg0 !== GBLANK) begin errors++; $display("FAIL lz_blank got=%b/%h want=1000/%h", an0, seg0, GBLANK); end
    wait_cycle(770);
    checks++; if (an0 !== 4'b0001 || seg0 !== G0) begin errors++; $display("FAIL zero_units got=%b/%h want=0001/%h", an0, seg0, G0); end
    wait_cycle(780);
    ms_hour = 8'h3A; ls_hour = 8'h2D;
    wait_cycle(850);
    checks++; if (an0 !== 4'b1000 || seg0 !== GBLANK) begin errors++; $display("FAIL invalid_blank got=%b/%h want=1000/%h", an0, seg0, GBLANK); end
    wait_cycle(920);
    checks++; if (an0 !== 4'b0100 || seg0 !== GDASH) begin errors++; $display("FAIL dash got=%b/%h want=0100/%h", an0, seg0, GDASH); end
  endtask

  task automatic test_display_en;
    wait_cycle(1000);
    display_en = 1'b0;
    wait_cycle(1001);
    checks++; if ({seg0, an0, colon0} !== 12'h000) begin errors++; $display("FAIL dark_cc got=%h/%b/%b want=00/0000/0", seg0, an0, colon0); end
    checks++; if ({seg1, an1, colon1, dp1} !== 13'h1FFF) begin errors++; $display("FAIL dark_ca got=%h want=1fff", {seg1, an1, colon1, dp1}); end
    wait_cycle(1010);
    display_en = 1'b1;
    wait_cycle(1011);
    checks++; if (an0 !== 4'b0010 || seg0 !== G2 || colon0 !== 1'b1) begin errors++; $display("FAIL resume got=%b/%h/%b want=0010/%h/1", an0, seg0, colon0, G2); end
  endtask

  task automatic test_alarm_flash;
    wait_cycle(1030);
    alarm_sound = 1'b1;
    wait_cycle(1040);
    checks++; if (an0 !== 4'b0000 || colon0 !== 1'b0) begin errors++; $display("FAIL flash_dark got=%b/%b want=0000/0", an0, colon0); end
    wait_cycle(1280);
    checks++; if (an0 !== 4'b0000) begin errors++; $display("FAIL flash_dark_end got=%b want=0000", an0); end
    wait_cycle(1281);
    checks++; if (an0 !== 4'b0001 || seg0 !== G0 || colon0 !== 1'b1) begin errors++; $display("FAIL flash_lit got=%b/%h/%b want=0001/%h/1", an0, seg0, colon0, G0); end
    wait_cycle(1536);
    checks++; if (an0 !== 4'b0010 || colon0 !== 1'b1) begin errors++; $display("FAIL flash_lit_end got=%b/%b want=0010/1", an0, colon0); end
    wait_cycle(1537);
    checks++; if (an0 !== 4'b0000 || colon0 !== 1'b0) begin errors++; $display("FAIL flash_dark2 got=%b/%b want=0000/0", an0, colon0); end
    wait_cycle(1600);
    alarm_sound = 1'b0;
    wait_cycle(1601);
    checks++; if (an0 !== 4'b1000 || seg0 !== GBLANK || colon0 !== 1'b0) begin errors++; $display("FAIL alarm_off got=%b/%h/%b want=1000/%h/0", an0, seg0, colon0, GBLANK); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_latch();
    test_blanking();
    test_display_en();
    test_alarm_flash();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
